// File: rtl/cordic_pkg.sv
// Shared types and defaults for the pipelined CORDIC core.
package cordic_pkg;

    typedef logic [1:0] quadrant_t;

    typedef struct packed {
        logic      done;
        quadrant_t quadrant;
    } tag_t;

    localparam int unsigned DEFAULT_BIT_WIDTH = 16;
    localparam logic [DEFAULT_BIT_WIDTH-1:0] DEFAULT_X_INIT = 16'h4DBA;

    // Rounds the phase to the nearest quadrant; the top bit of the residual field
    // marks the upper half of the current quadrant.
    function automatic quadrant_t fold_quadrant(input logic [1:0] hi, input logic half);
        return hi + {1'b0, half};
    endfunction

endpackage

// File: rtl/cordic_angle_reducer_if.sv
// Phase-word valid/ready handshake into the CORDIC angle reducer.
interface cordic_angle_reducer_if #(
    parameter int unsigned BIT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH+1:0] in_phase;

    modport master (output in_valid, output in_phase, input in_ready);
    modport slave (input in_valid, input in_phase, output in_ready);
endinterface

// File: rtl/cordic_tag_delay.sv
// Shift-on-enable delay line of {done, quadrant} tags, synchronously reset.
module cordic_tag_delay
    import cordic_pkg::*;
#(
    parameter int unsigned DEPTH = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t chain_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                chain_q[i] <= '0;
            end
        end else if (enable) begin
            chain_q[0] <= in_tag;
            for (int i = 1; i < int'(DEPTH); i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign out_tag = chain_q[DEPTH-1];

endmodule

// File: rtl/cordic_angle_reducer.sv
// CORDIC front end: buffers phase words, folds them to quadrant + residual and
// seeds stage 0, carrying the quadrant alongside the pipeline in a tag line.
module cordic_angle_reducer
    import cordic_pkg::*;
#(
    parameter int unsigned          BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int unsigned          STAGES    = 16,
    parameter logic [BIT_WIDTH-1:0] X_INIT    = DEFAULT_X_INIT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    cordic_angle_reducer_if.slave       in_bus,
    output logic signed [BIT_WIDTH-1:0] out_target_angle,
    output logic signed [BIT_WIDTH:0]   out_current_angle,
    output logic signed [BIT_WIDTH-1:0] out_x,
    output logic signed [BIT_WIDTH-1:0] out_y,
    output logic                        out_done,
    output quadrant_t                   tail_quadrant,
    output logic                        tail_done
);

    logic [BIT_WIDTH+1:0] fifo_q [2];
    logic                 head_q;
    logic                 tail_q;
    logic [1:0]           count_q;

    logic signed [BIT_WIDTH-1:0] target_q;
    logic signed [BIT_WIDTH-1:0] x_q;
    logic                        done_q;

    logic                 push;
    logic                 pop;
    logic [BIT_WIDTH+1:0] head_phase;
    quadrant_t            head_quadrant;
    tag_t                 seed_tag;
    tag_t                 tail_tag;

    assign in_bus.in_ready = (count_q < 2'd2) & ~reset;
    assign push = in_bus.in_valid & in_bus.in_ready;
    assign pop  = start & (count_q != 2'd0);

    assign head_phase    = fifo_q[head_q];
    assign head_quadrant = fold_quadrant(head_phase[BIT_WIDTH+1:BIT_WIDTH],
                                         head_phase[BIT_WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
            target_q <= '0;
            x_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= in_bus.in_phase;
                tail_q         <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
            if (start) begin
                // An empty start emits a bubble; x is deliberately held.
                done_q   <= pop;
                target_q <= pop ? $signed(head_phase[BIT_WIDTH-1:0]) : '0;
                if (pop) begin
                    x_q <= X_INIT;
                end
            end
        end
    end

    assign seed_tag = '{done: pop, quadrant: pop ? head_quadrant : quadrant_t'(0)};

    cordic_tag_delay #(
        .DEPTH(STAGES + 1)
    ) u_tag_delay (
        .clk    (clk),
        .reset  (reset),
        .enable (start),
        .in_tag (seed_tag),
        .out_tag(tail_tag)
    );

    // The seed always starts from the x axis with no accumulated rotation.
    assign out_current_angle = '0;
    assign out_y             = '0;
    assign out_target_angle  = target_q;
    assign out_x             = x_q;
    assign out_done          = done_q;
    assign tail_quadrant     = tail_tag.quadrant;
    assign tail_done         = tail_tag.done;

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Directed bench for cordic_angle_reducer (BIT_WIDTH=16, STAGES=4).
module tb_cordic_angle_reducer;

    localparam int unsigned BW = 16;
    localparam int unsigned ST = 4;
    localparam logic [15:0] XI = 16'h4DBA;

    typedef struct {
        logic [17:0] phase;
        int          exp_q;
        int          exp_res;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic signed [15:0] out_target_angle;
    logic signed [16:0] out_current_angle;
    logic signed [15:0] out_x;
    logic signed [15:0] out_y;
    logic               out_done;
    logic [1:0]         tail_quadrant;
    logic               tail_done;

    int checks = 0;
    int errors = 0;

    cordic_angle_reducer_if #(.BIT_WIDTH(BW)) bus ();

    cordic_angle_reducer #(
        .BIT_WIDTH(BW),
        .STAGES   (ST),
        .X_INIT   (XI)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .in_bus           (bus),
        .out_target_angle (out_target_angle),
        .out_current_angle(out_current_angle),
        .out_x            (out_x),
        .out_y            (out_y),
        .out_done         (out_done),
        .tail_quadrant    (tail_quadrant),
        .tail_done        (tail_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] phase);
        bus.in_valid = 1'b1;
        bus.in_phase = phase;
        check("push_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_seed(input string name, input int res);
        check({name, "_done"}, 32'(out_done), 1);
        check({name, "_target"}, 32'(out_target_angle), res);
        check({name, "_x"}, 32'(out_x), 32'(signed'(XI)));
        check({name, "_y"}, 32'(out_y), 0);
        check({name, "_cur"}, 32'(out_current_angle), 0);
    endtask

    vec_t        vecs [6];
    logic [17:0] words [4];
    int          idx;
    logic        acc;

    initial begin
        vecs[0] = '{18'h00000, 0, 0};
        vecs[1] = '{18'h08000, 1, -32768};
        vecs[2] = '{18'h10000, 1, 0};
        vecs[3] = '{18'h2C000, 3, -16384};
        vecs[4] = '{18'h3FFFF, 0, -1};
        vecs[5] = '{18'h18000, 2, -32768};
        words[0] = 18'h00010;
        words[1] = 18'h10010;
        words[2] = 18'h20010;
        words[3] = 18'h30010;

        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_phase = '0;
        #1;
        tick();
        check("rst_ready", 32'(bus.in_ready), 0);
        tick();
        check("rst_target", 32'(out_target_angle), 0);
        check("rst_x", 32'(out_x), 0);
        check("rst_done", 32'(out_done), 0);
        check("rst_tail_done", 32'(tail_done), 0);
        check("rst_tail_q", 32'(tail_quadrant), 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.in_ready), 1);

        // Quadrant folding: seed on the next start, quadrant at the tail ST starts later.
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].phase);
            do_start();
            check_seed($sformatf("vec%0d", i), vecs[i].exp_res);
            repeat (ST) do_start();
            check($sformatf("vec%0d_tail_done", i), 32'(tail_done), 1);
            check($sformatf("vec%0d_tail_q", i), 32'(tail_quadrant), vecs[i].exp_q);
        end

        // Empty start: bubble seed holds x, bubble tag follows the sample out.
        push(18'h04000);
        do_start();
        check_seed("empty_pre", 16384);
        do_start();
        check("empty_done", 32'(out_done), 0);
        check("empty_target", 32'(out_target_angle), 0);
        check("empty_x_held", 32'(out_x), 32'(signed'(XI)));
        repeat (ST - 1) do_start();
        check("empty_tail_sample", 32'(tail_done), 1);
        do_start();
        check("empty_tail_bubble", 32'(tail_done), 0);

        // Full FIFO backpressure, then one pop frees space for the third word.
        bus.in_valid = 1'b1;
        bus.in_phase = 18'h00100;
        check("bp_ready0", 32'(bus.in_ready), 1);
        tick();
        bus.in_phase = 18'h00200;
        check("bp_ready1", 32'(bus.in_ready), 1);
        tick();
        bus.in_phase = 18'h00300;
        check("bp_full", 32'(bus.in_ready), 0);
        tick();
        check("bp_still_full", 32'(bus.in_ready), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bp_pop_a", 32'(out_target_angle), 256);
        check("bp_freed", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_full_again", 32'(bus.in_ready), 0);
        do_start();
        check("bp_pop_b", 32'(out_target_angle), 512);
        do_start();
        check_seed("bp_pop_c", 768);
        do_start();
        check("bp_empty", 32'(out_done), 0);

        // Push and pop together at count 1: older word leaves, newer stays.
        push(18'h01000);
        bus.in_valid = 1'b1;
        bus.in_phase = 18'h02000;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
        check("pp1_old", 32'(out_target_angle), 4096);
        check("pp1_done", 32'(out_done), 1);
        check("pp1_ready", 32'(bus.in_ready), 1);
        do_start();
        check_seed("pp1_new", 8192);
        do_start();
        check("pp1_drained", 32'(out_done), 0);

        // Push and start together at count 0: no bypass.
        bus.in_valid = 1'b1;
        bus.in_phase = 18'h03000;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
        check("pp0_bubble", 32'(out_done), 0);
        check("pp0_bubble_target", 32'(out_target_angle), 0);
        do_start();
        check_seed("pp0_word", 12288);
        do_start();
        check("pp0_drained", 32'(out_done), 0);

        // Alignment with continuous start and back-to-back input.
        repeat (ST + 1) do_start();
        push(words[0]);
        push(words[1]);
        check("al_full", 32'(bus.in_ready), 0);
        idx = 2;
        for (int s = 1; s <= 9; s++) begin
            start = 1'b1;
            bus.in_valid = (idx < 4);
            bus.in_phase = (idx < 4) ? words[idx] : '0;
            acc = bus.in_valid & bus.in_ready;
            tick();
            if (acc) idx++;
            if (s <= 4) begin
                check($sformatf("al_seed%0d_done", s), 32'(out_done), 1);
                check($sformatf("al_seed%0d_target", s), 32'(out_target_angle), 16);
                check($sformatf("al_pre_tail%0d", s), 32'(tail_done), 0);
            end else if (s <= 8) begin
                check($sformatf("al_tail%0d_done", s), 32'(tail_done), 1);
                check($sformatf("al_tail%0d_q", s), 32'(tail_quadrant), s - 5);
            end else begin
                check("al_tail_end", 32'(tail_done), 0);
            end
        end
        start = 1'b0;
        bus.in_valid = 1'b0;

        // Reset mid-stream drops buffered words and in-flight tags.
        push(18'h05000);
        do_start();
        check_seed("mr_pre", 20480);
        push(18'h06000);
        push(18'h07000);
        reset = 1'b1;
        #1;
        check("mr_ready_in_reset", 32'(bus.in_ready), 0);
        tick();
        reset = 1'b0;
        #1;
        check("mr_target", 32'(out_target_angle), 0);
        check("mr_x", 32'(out_x), 0);
        check("mr_done", 32'(out_done), 0);
        check("mr_tail_done", 32'(tail_done), 0);
        check("mr_ready_after", 32'(bus.in_ready), 1);
        do_start();
        check("mr_no_seed", 32'(out_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_angle_reducer.md
# cordic_angle_reducer

Front-end stage of the pipelined CORDIC core. It accepts full-circle phase words over a valid/ready handshake and buffers them in a 2-entry FIFO. On each pipeline advance it folds the phase into a quadrant index plus a residual angle in [-π/4, π/4), and presents the stage-0 seed (target angle, zero current angle, x = X_INIT, y = 0, done). It also carries each sample's quadrant through a tag delay line, so the output fixer receives it aligned with the last CORDIC stage.

## Interface
- BIT_WIDTH, 16, data/angle width; must match the `cordic_stage` instances.
- STAGES, 16, number of `cordic_stage` instances downstream; sets the tag delay-line depth; ≥1.
- X_INIT, 16'h4DBA, initial x (CORDIC gain compensation 1/K scaled to BIT_WIDTH); BIT_WIDTH wide.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pipeline advance strobe, shared with every `cordic_stage`
- in_valid  in  1  phase word offered
- in_ready  out  1  FIFO can accept
- in_phase  in  BIT_WIDTH+2  unsigned phase; full circle = 2^(BIT_WIDTH+2), π/2 = 2^BIT_WIDTH
- out_target_angle  out  BIT_WIDTH signed  residual angle to stage 0; π/4 = 2^(BIT_WIDTH-1)
- out_current_angle  out  BIT_WIDTH+1 signed  always 0
- out_x, out_y  out  BIT_WIDTH signed each  seed vector
- out_done  out  1  seed is a real sample
- tail_quadrant  out  2  quadrant of the sample currently leaving stage STAGES-1
- tail_done  out  1  tail_quadrant belongs to a real sample

## Operation
- Reduction is pure wiring on the FIFO head:
  - q = in_phase[BIT_WIDTH+1:BIT_WIDTH] + in_phase[BIT_WIDTH-1], mod 4.
  - residual = $signed(in_phase[BIT_WIDTH-1:0]).
  - Example: phase = 3·2^(BIT_WIDTH-1) gives q=2, residual=-2^(BIT_WIDTH-1).
- FIFO: 2 entries. Each entry holds the full phase word; head and tail pointers wrap mod 2; count ranges 0..2.
  - in_ready = (count < 2) & ~reset.
  - Push when in_valid & in_ready.
- On start:
  - If count > 0: pop the head. Load out_target_angle = residual, out_x = X_INIT, out_y = 0, out_current_angle = 0, out_done = 1. Shift {1, q} into tag line position 0.
  - If count == 0: out_done = 0 and out_target_angle = 0; out_x and out_y are held. Shift {0, 0} into the tag line.
- Tag line: STAGES+1 registers of {done, quadrant}. Position 0 aligns with the seed register; position k aligns with stage k-1's output register. tail_* = position STAGES.
  - The line shifts on every start. A stage that skips the load (in_done = out_done = 0) holds a bubble equivalent to the shifted bubble, so alignment is preserved.
- Simultaneous push and pop:
  - count unchanged; the popped entry is the old head.
  - With count == 0, a simultaneous push does not bypass. That start emits a bubble, and the new word is popped on the next start.
  - With count == 2, in_ready is 0, so no push occurs; space frees on the cycle after a pop.
- Reset has priority over start and push. It clears the FIFO (count = 0, pointers = 0) and the whole tag line; in-flight samples are dropped.

## Timing
- Reset values: out_target_angle 0, out_current_angle 0, out_x 0, out_y 0, out_done 0, tail_quadrant 0, tail_done 0; in_ready 0 during reset, 1 on the first cycle after.
- Accept to seed: a word pushed in cycle n appears on out_* after the first start in a cycle > n that finds it at the head. Minimum is 1 clock after acceptance.
- Seed to tail: the tag exits tail_* exactly STAGES start strobes after its seed loaded. This matches the `cordic_stage` chain latency in strobes.
- in_ready is combinational from count only; no combinational path from in_valid to in_ready.
- Continuous start with back-to-back valid input sustains 1 sample per start.

## Structure
- Shared package `cordic_pkg`: quadrant_t (2-bit typedef), tag_t struct {done, quadrant}, default X_INIT per BIT_WIDTH, helper function for quadrant extraction.
- One sub-module: `cordic_tag_delay` (parameterised depth, shift-on-enable register chain of tag_t, synchronous reset). It is reused later by the output fixer.
- FIFO is inline (2 entries, too small for a generic FIFO).

## Test plan
- Reset mid-stream: push 2 words, assert reset 1 cycle → count 0, all outputs 0, in_ready 0 during reset and 1 after; no seed emitted on the next start.
- Quadrant folding (BIT_WIDTH=16): phases 0, 0x08000, 0x10000, 0x2C000, 0x3FFFF → (q, residual) = (0, 0), (1, -32768), (1, 0), (3, -16384), (0, -1).
- Full/backpressure: start held low, offer 3 words → first two accepted, in_ready low on the third; one start → third accepted the following cycle; order preserved.
- Empty start: count 0, start pulse → out_done 0, bubble tag enters; after STAGES starts, tail_done 0.
- Alignment (STAGES=4): push words with q = 0,1,2,3 and a continuous start → tail_quadrant sequence 0,1,2,3 with tail_done 1, beginning on the 4th start after the first seed.
- Simultaneous push/pop at count 1 → count stays 1, the popped word is the older one, the next start emits the pushed word.
